// File: rtl/axi_s6_mem_slave.sv
// AXI slave terminating the interconnect S6 port: INCR-only word memory with byte strobes,
// independent single-outstanding read and write FSMs, SLVERR for beats beyond MEM_DEPTH.
module axi_s6_mem_slave #(
   parameter int unsigned MEM_DEPTH  = 1024,
   parameter int unsigned ID_WIDTH   = 4,
   parameter int unsigned ADDR_WIDTH = 32
) (
   input  logic                  ACLK,
   input  logic                  ARESETn,
   input  logic [ID_WIDTH-1:0]   AWID,
   input  logic [ADDR_WIDTH-1:0] AWADDR,
   input  logic [3:0]            AWLEN,
   input  logic                  AWVALID,
   output logic                  AWREADY,
   input  logic [31:0]           WDATA,
   input  logic [3:0]            WSTRB,
   input  logic                  WLAST,
   input  logic                  WVALID,
   output logic                  WREADY,
   output logic [ID_WIDTH-1:0]   BID,
   output logic [1:0]            BRESP,
   output logic                  BVALID,
   input  logic                  BREADY,
   input  logic [ID_WIDTH-1:0]   ARID,
   input  logic [ADDR_WIDTH-1:0] ARADDR,
   input  logic [3:0]            ARLEN,
   input  logic                  ARVALID,
   output logic                  ARREADY,
   output logic [ID_WIDTH-1:0]   RID,
   output logic [31:0]           RDATA,
   output logic [1:0]            RRESP,
   output logic                  RLAST,
   output logic                  RVALID,
   input  logic                  RREADY
);

   localparam int unsigned MemAw    = $clog2(MEM_DEPTH);
   // One spare bit so a burst running past index 16383 still reads as out of range
   localparam logic [14:0] DepthIdx = 15'(MEM_DEPTH);
   localparam logic [1:0]  RespOkay = 2'b00;
   localparam logic [1:0]  RespSlv  = 2'b10;

   typedef enum logic [1:0] {WIdle, WData, WResp} w_state_e;
   typedef enum logic {RIdle, RData} r_state_e;

   logic [31:0] mem [MEM_DEPTH];

   w_state_e            w_state_q, w_state_d;
   logic                awready_q, awready_d;
   logic                wready_q, wready_d;
   logic                bvalid_q, bvalid_d;
   logic [ID_WIDTH-1:0] bid_q, bid_d;
   logic [1:0]          bresp_q, bresp_d;
   logic [14:0]         widx_q, widx_d;
   logic [3:0]          wlen_q, wlen_d;
   logic [3:0]          wcnt_q, wcnt_d;
   logic                werr_q, werr_d;
   logic                mem_we;
   logic                w_in_range;
   logic                w_last_beat;

   r_state_e            r_state_q, r_state_d;
   logic                arready_q, arready_d;
   logic                rvalid_q, rvalid_d;
   logic                rlast_q, rlast_d;
   logic [ID_WIDTH-1:0] rid_q, rid_d;
   logic [31:0]         rdata_q, rdata_d;
   logic [1:0]          rresp_q, rresp_d;
   logic [14:0]         ridx_q, ridx_d;
   logic [3:0]          rlen_q, rlen_d;
   logic [3:0]          rcnt_q, rcnt_d;
   logic                r_load;

   logic unused_addr;
   assign unused_addr = ^{AWADDR[ADDR_WIDTH-1:16], AWADDR[1:0],
                          ARADDR[ADDR_WIDTH-1:16], ARADDR[1:0]};

   assign w_in_range  = (widx_q < DepthIdx);
   assign w_last_beat = (wcnt_q == wlen_q);

   always_comb begin
      w_state_d = w_state_q;
      awready_d = awready_q;
      wready_d  = wready_q;
      bvalid_d  = bvalid_q;
      bid_d     = bid_q;
      bresp_d   = bresp_q;
      widx_d    = widx_q;
      wlen_d    = wlen_q;
      wcnt_d    = wcnt_q;
      werr_d    = werr_q;
      mem_we    = 1'b0;
      unique case (w_state_q)
         WIdle: begin
            awready_d = 1'b1;
            if (AWVALID && awready_q) begin
               awready_d = 1'b0;
               wready_d  = 1'b1;
               bid_d     = AWID;
               widx_d    = {1'b0, AWADDR[15:2]};
               wlen_d    = AWLEN;
               wcnt_d    = '0;
               werr_d    = 1'b0;
               w_state_d = WData;
            end
         end
         WData: begin
            if (WVALID && wready_q) begin
               mem_we = w_in_range;
               // Burst length comes from AWLEN; WLAST only flags a protocol error
               werr_d = werr_q | ~w_in_range | (WLAST != w_last_beat);
               if (w_last_beat) begin
                  wready_d  = 1'b0;
                  bvalid_d  = 1'b1;
                  bresp_d   = werr_d ? RespSlv : RespOkay;
                  w_state_d = WResp;
               end else begin
                  wcnt_d = wcnt_q + 4'd1;
                  widx_d = widx_q + 15'd1;
               end
            end
         end
         WResp: begin
            if (BREADY && bvalid_q) begin
               bvalid_d  = 1'b0;
               awready_d = 1'b1;
               w_state_d = WIdle;
            end
         end
         default: w_state_d = WIdle;
      endcase
   end

   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         w_state_q <= WIdle;
         awready_q <= 1'b0;
         wready_q  <= 1'b0;
         bvalid_q  <= 1'b0;
         bid_q     <= '0;
         bresp_q   <= '0;
         widx_q    <= '0;
         wlen_q    <= '0;
         wcnt_q    <= '0;
         werr_q    <= 1'b0;
      end else begin
         w_state_q <= w_state_d;
         awready_q <= awready_d;
         wready_q  <= wready_d;
         bvalid_q  <= bvalid_d;
         bid_q     <= bid_d;
         bresp_q   <= bresp_d;
         widx_q    <= widx_d;
         wlen_q    <= wlen_d;
         wcnt_q    <= wcnt_d;
         werr_q    <= werr_d;
      end
   end

   // Array is deliberately not reset so contents survive ARESETn
   always_ff @(posedge ACLK) begin
      if (mem_we) begin
         for (int b = 0; b < 4; b++) begin
            if (WSTRB[b]) mem[widx_q[MemAw-1:0]][8*b +: 8] <= WDATA[8*b +: 8];
         end
      end
   end

   always_comb begin
      r_state_d = r_state_q;
      arready_d = arready_q;
      rvalid_d  = rvalid_q;
      rlast_d   = rlast_q;
      rid_d     = rid_q;
      rdata_d   = rdata_q;
      rresp_d   = rresp_q;
      ridx_d    = ridx_q;
      rlen_d    = rlen_q;
      rcnt_d    = rcnt_q;
      r_load    = 1'b0;
      unique case (r_state_q)
         RIdle: begin
            arready_d = 1'b1;
            if (ARVALID && arready_q) begin
               arready_d = 1'b0;
               rvalid_d  = 1'b1;
               rid_d     = ARID;
               rlen_d    = ARLEN;
               rcnt_d    = '0;
               ridx_d    = {1'b0, ARADDR[15:2]};
               rlast_d   = (ARLEN == 4'd0);
               r_load    = 1'b1;
               r_state_d = RData;
            end
         end
         RData: begin
            if (rvalid_q && RREADY) begin
               if (rlast_q) begin
                  rvalid_d  = 1'b0;
                  rlast_d   = 1'b0;
                  arready_d = 1'b1;
                  r_state_d = RIdle;
               end else begin
                  rcnt_d  = rcnt_q + 4'd1;
                  ridx_d  = ridx_q + 15'd1;
                  rlast_d = (rcnt_d == rlen_q);
                  r_load  = 1'b1;
               end
            end
         end
         default: r_state_d = RIdle;
      endcase
      // Read sampled before a same-edge write lands, so it sees the old word
      if (r_load) begin
         if (ridx_d < DepthIdx) begin
            rdata_d = mem[ridx_d[MemAw-1:0]];
            rresp_d = RespOkay;
         end else begin
            rdata_d = '0;
            rresp_d = RespSlv;
         end
      end
   end

   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         r_state_q <= RIdle;
         arready_q <= 1'b0;
         rvalid_q  <= 1'b0;
         rlast_q   <= 1'b0;
         rid_q     <= '0;
         rdata_q   <= '0;
         rresp_q   <= '0;
         ridx_q    <= '0;
         rlen_q    <= '0;
         rcnt_q    <= '0;
      end else begin
         r_state_q <= r_state_d;
         arready_q <= arready_d;
         rvalid_q  <= rvalid_d;
         rlast_q   <= rlast_d;
         rid_q     <= rid_d;
         rdata_q   <= rdata_d;
         rresp_q   <= rresp_d;
         ridx_q    <= ridx_d;
         rlen_q    <= rlen_d;
         rcnt_q    <= rcnt_d;
      end
   end

   assign AWREADY = awready_q;
   assign WREADY  = wready_q;
   assign BVALID  = bvalid_q;
   assign BID     = bid_q;
   assign BRESP   = bresp_q;
   assign ARREADY = arready_q;
   assign RVALID  = rvalid_q;
   assign RLAST   = rlast_q;
   assign RID     = rid_q;
   assign RDATA   = rdata_q;
   assign RRESP   = rresp_q;

endmodule
